// File: rtl/scan_reg_bank.sv
// Scannable register file: DEPTH x WIDTH flops with one write port, a registered
// true/complement read port, synchronous bank clear and a full-bank serial scan chain.

module scan_reg_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclr,
  input  logic             se,
  input  logic             we,
  input  logic [WIDTH-1:0] sdat,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (sclr) q <= '0;
    else if (se)   q <= sdat;
    else if (we)   q <= d;
  end

endmodule

module scan_reg_bank #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             SCLR,
  input  logic             SE,
  input  logic             SI,
  output logic             SO,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    RA,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB
);

  localparam int NB = DEPTH * WIDTH;
  localparam int NR = 1 << AW;

  logic [DEPTH-1:0][WIDTH-1:0] word;
  logic [NB-1:0]               flat;
  logic [NB-1:0]               chain;
  logic [DEPTH-1:0]            we_hit;
  logic [NR-1:0][WIDTH-1:0]    rd_tbl;

  // chain[i] is the value bit i of the flattened bank takes on a shift edge
  assign flat     = word;
  assign chain[0] = SI;
  for (genvar i = 1; i < NB; i++) begin : g_chain
    assign chain[i] = flat[i-1];
  end

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    assign we_hit[w] = WE && (WA == AW'(w));
    scan_reg_word #(.WIDTH(WIDTH)) u_word (
      .clk  (CLK),
      .rst  (CLR),
      .sclr (SCLR),
      .se   (SE),
      .we   (we_hit[w]),
      .sdat (chain[w*WIDTH +: WIDTH]),
      .d    (D),
      .q    (word[w])
    );
  end

  // Unused address space reads as zero so no X leaks from beyond DEPTH
  for (genvar r = 0; r < NR; r++) begin : g_rd
    if (r < DEPTH) begin : g_live
      assign rd_tbl[r] = word[r];
    end else begin : g_void
      assign rd_tbl[r] = '0;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)       Q <= '0;
    else if (SCLR) Q <= '0;
    else           Q <= rd_tbl[RA];
  end

  assign QB = ~Q;
  assign SO = flat[NB-1];

endmodule

// File: doc/scan_reg_bank.md
# scan_reg_bank

Parametrised, scannable register bank built as the sequential successor to the single-bit two-output flop cell: DEPTH words of WIDTH bits with one synchronous write port, one registered read port with true and complement outputs, a synchronous bank clear, and a full-bank serial scan chain. It is used wherever the datapath needs a small addressed register file that must also be loadable and observable through the test chain.

## Interface
Parameters:
- WIDTH, 8, bits per word (≥1)
- DEPTH, 4, number of words (≥1; need not be a power of two)
- AW, max(1, clog2(DEPTH)), address width (derived, not overridden)

Ports:
- CLK  input  1  clock; all state changes on rising edge
- CLR  input  1  reset, asynchronous, active-high; clears all state immediately
- SCLR  input  1  synchronous clear of all words and Q
- SE  input  1  scan enable; shifts the whole bank one bit per cycle
- SI  input  1  scan serial input
- SO  output  1  scan serial output
- WE  input  1  write enable
- WA  input  AW  write address
- D  input  WIDTH  write data
- RA  input  AW  read address
- Q  output  WIDTH  registered read data
- QB  output  WIDTH  bitwise complement of Q

## Operation
- Storage: word[0..DEPTH-1], each WIDTH bits, all flops.
- Per-edge priority, highest first: CLR (async) > SCLR > SE > WE > hold.
- CLR=1: all words, Q and SO go to 0 immediately, no clock needed; QB=all ones. Held while CLR=1; edges ignored.
- SCLR=1 (CLR=0): all words and Q cleared at the edge; SE and WE ignored that cycle.
- SE=1: chain order SI -> word[0][0] -> word[0][1] -> … -> word[0][WIDTH-1] -> word[1][0] -> … -> word[DEPTH-1][WIDTH-1] -> SO. Each edge moves every bit one position; SI enters word[0][0]; old word[DEPTH-1][WIDTH-1] is discarded. WE ignored. Chain length DEPTH*WIDTH.
- SO = word[DEPTH-1][WIDTH-1] directly from the flop (no extra stage, no combinational path from SI).
- WE=1, SE=0: word[WA] <= D. WA ≥ DEPTH: write dropped, no state changes.
- Read: every edge with CLR=0 and SCLR=0, Q <= word[RA] using pre-edge contents (read-before-write on same address; during shift Q captures the pre-shift word). RA ≥ DEPTH: Q <= 0.
- QB = ~Q, combinational from Q; never drives an independent state.
- No X propagation from unused address space: out-of-range reads return 0.

## Timing
- Reset values: all words 0, Q=0, QB={WIDTH{1}}, SO=0.
- Write latency: data written at edge k visible on Q after edge k+1 (RA=WA held).
- Read latency: 1 cycle from RA to Q.
- Scan: full unload/load takes DEPTH*WIDTH edges with SE=1; first bit out (word[DEPTH-1][WIDTH-1]) is valid on SO before the first shift edge.
- SE may toggle any cycle; no pipeline to drain, mode takes effect at the next edge.
- CLR assertion mid-shift or mid-write: state zeroed asynchronously; partial operation lost. CLR deassertion is synchronised externally; first functional edge is the first rising CLK after CLR falls.
- DEPTH=1: AW=1, address 1 is out of range for both ports.

## Test plan
- Reset: drive random state, assert CLR without clock -> Q=0x00, QB=0xFF, SO=0 immediately; release, one edge with WE=0 -> still 0x00.
- Write/read: WIDTH=8, DEPTH=4, WE=1 WA=2 D=0xA5, RA=2 -> after 2nd edge Q=0xA5, QB=0x5A; same-edge read of WA=2 with D=0x3C shows 0xA5 then 0x3C next edge.
- Scan unload/load: write word3=0x80, others 0 -> SO=1 before shifting; SE=1 with SI=1 for 32 edges -> all words 0xFF, SO sequence 1 then 31 zeros.
- Priority: SE=1 and WE=1 WA=0 D=0x55 same edge -> shift only, word0 bit0=SI, no write; SCLR=1 with SE=1 and WE=1 -> all words 0.
- Out-of-range: DEPTH=3, WE=1 WA=3 D=0xFF -> no word changes; RA=3 -> Q=0x00, QB=0xFF.
- Async reset mid-operation: CLR pulsed between edges during 16th shift -> all outputs 0 at once, subsequent scan out yields 32 zeros.
